tbus_enable_ctrl: RTL and testbench

Registered enable sequencer for a shared tristate bus built from tristate buffer cells (INP/ENB/Z). Sits directly upstream of one bus driver per requester: each ENB[i] output connects straight to the ENB pin of requester i's tristate driver. It arbitrates requests round-robin, keeps at most one driver enabled, and inserts a programmable all-off turnaround gap between owners so that no two drivers ever fight on Z.

---
 rtl/tbus_enable_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_tbus_enable_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tbus_enable_ctrl.sv
// tbus_enable_ctrl: registered enable sequencer for a shared tristate bus.
// Grants one requester at a time (round-robin), drives the matching ENB pin,
// and forces TA_CYC all-off cycles between different owners.
// Optional feature: define TBUS_PARK_EN to park the last owner's ENB high
// while the bus is idle so that Z never floats.
module tbus_enable_ctrl #(
  parameter int N        = 4,
  parameter int TA_CYC   = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         REQ,
  input  logic [N-1:0]         LAST,
  output logic [N-1:0]         GNT,
  output logic [N-1:0]         ENB,
  output logic [$clog2(N)-1:0] OWNER,
  output logic                 BUSY
);

  localparam int OW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_gnt;
  logic [N-1:0]    r_enb;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_ptr;
  logic [HW-1:0]   r_hold;
  logic [2:0]      r_turn;
  logic            r_park;

  state_t          w_state_next;
  logic [N-1:0]    w_gnt_next;
  logic [N-1:0]    w_enb_next;
  logic [OW-1:0]   w_owner_next;
  logic [OW-1:0]   w_ptr_next;
  logic [HW-1:0]   w_hold_next;
  logic [2:0]      w_turn_next;
  logic            w_park_next;

  logic            w_any;
  logic [OW-1:0]   w_win;
  logic [N-1:0]    w_win_oh;
  logic [OW-1:0]   w_ptr_after;
  logic            w_release;
  logic            w_grant;

  // Round-robin search: first request at or after the pointer, wrapping.
  // Scanning offsets from high to low lets the smallest offset win.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (REQ[(int'(r_ptr) + k) % N]) begin
        w_any = 1'b1;
        w_win = OW'((int'(r_ptr) + k) % N);
      end
    end
  end

  // One-hot decode of the arbitration winner.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_win_dec
      assign w_win_oh[gi] = (w_win == OW'(gi));
    end
  endgenerate

`ifdef TBUS_PARK_EN
  logic [N-1:0] w_own_oh;
  generate
    for (gi = 0; gi < N; gi++) begin : g_own_dec
      assign w_own_oh[gi] = (r_owner == OW'(gi));
    end
  endgenerate
`endif

  assign w_ptr_after = (w_win == OW'(N - 1)) ? '0 : w_win + OW'(1);

  // The owner gives up the bus on LAST, on dropping its request, or on timeout.
  assign w_release = LAST[r_owner] | ~REQ[r_owner] | (r_hold == HW'(MAX_HOLD));

  // Next-state and next-output logic for the IDLE/DRIVE/TURN sequencer.
  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_enb_next   = r_enb;
    w_owner_next = r_owner;
    w_ptr_next   = r_ptr;
    w_hold_next  = r_hold;
    w_turn_next  = r_turn;
    w_park_next  = r_park;
    w_grant      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
`ifdef TBUS_PARK_EN
          if (r_park && (w_win != r_owner)) begin
            // A different requester must wait out a full turnaround
            // after the parked driver lets go.
            w_state_next = S_TURN;
            w_gnt_next   = '0;
            w_enb_next   = '0;
            w_turn_next  = 3'(TA_CYC);
            w_park_next  = 1'b0;
          end else begin
            w_grant = 1'b1;
          end
`else
          w_grant = 1'b1;
`endif
        end
      end

      S_DRIVE: begin
        if (w_release) begin
          w_state_next = S_TURN;
          w_gnt_next   = '0;
          w_enb_next   = '0;
          w_turn_next  = 3'(TA_CYC);
        end else begin
          w_hold_next = r_hold + HW'(1);
        end
      end

      S_TURN: begin
        if (r_turn == 3'd1) begin
          if (w_any) begin
            w_grant = 1'b1;
          end else begin
            w_state_next = S_IDLE;
`ifdef TBUS_PARK_EN
            w_enb_next   = w_own_oh;
            w_park_next  = 1'b1;
`endif
          end
        end else begin
          w_turn_next = r_turn - 3'd1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_gnt_next   = '0;
        w_enb_next   = '0;
      end
    endcase

    if (w_grant) begin
      w_state_next = S_DRIVE;
      w_gnt_next   = w_win_oh;
      w_enb_next   = w_win_oh;
      w_owner_next = w_win;
      w_ptr_next   = w_ptr_after;
      w_hold_next  = HW'(1);
      w_park_next  = 1'b0;
    end
  end

  // State and output registers; reset drops every enable immediately.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_enb   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_turn  <= '0;
      r_park  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_enb   <= w_enb_next;
      r_owner <= w_owner_next;
      r_ptr   <= w_ptr_next;
      r_hold  <= w_hold_next;
      r_turn  <= w_turn_next;
      r_park  <= w_park_next;
    end
  end

  assign GNT   = r_gnt;
  assign ENB   = r_enb;
  assign OWNER = r_owner;
  assign BUSY  = (r_state != S_IDLE);

endmodule

// File: tb/tb_tbus_enable_ctrl.sv
// Testbench for tbus_enable_ctrl: directed scenarios followed by random
// REQ/LAST traffic, checked every cycle against a behavioural model plus
// bus-safety properties (single enable, turnaround gap, bounded wait).
module tb_tbus_enable_ctrl;

  localparam int N     = 4;
  localparam int TA    = 2;
  localparam int MH    = 16;
  localparam int BOUND = N * (MH + TA + 1);

  logic                 clk;
  logic                 RST;
  logic [N-1:0]         REQ;
  logic [N-1:0]         LAST;
  logic [N-1:0]         GNT;
  logic [N-1:0]         ENB;
  logic [$clog2(N)-1:0] OWNER;
  logic                 BUSY;

  tbus_enable_ctrl #(.N(N), .TA_CYC(TA), .MAX_HOLD(MH)) dut (
    .CLK   (clk),
    .RST   (RST),
    .REQ   (REQ),
    .LAST  (LAST),
    .GNT   (GNT),
    .ENB   (ENB),
    .OWNER (OWNER),
    .BUSY  (BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: who owns the bus, how long it has driven, how many
  // all-off cycles remain, where round-robin resumes, and whether parked.
  bit m_gnt;
  bit m_parked;
  int m_owner;
  int m_enb;     // index of the enabled driver, -1 when none
  int m_ptr;
  int m_held;
  int m_gap;     // remaining turnaround cycles, 0 when not turning

  // Property trackers.
  int last_idx;
  int zero_run;
  int waits [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gnt = 0; m_parked = 0; m_owner = 0; m_enb = -1;
    m_ptr = 0; m_held = 0; m_gap = 0;
    last_idx = -1; zero_run = 0;
    for (int i = 0; i < N; i++) waits[i] = 0;
  endtask

  function automatic int pick(input logic [N-1:0] req);
    for (int k = 0; k < N; k++)
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] last, input logic rst);
    int  w;
    bit  in_turn;
    if (rst) begin
      model_reset();
    end else if (m_gnt) begin
      if (last[m_owner] || !req[m_owner] || m_held == MH) begin
        m_gnt = 0; m_enb = -1; m_gap = TA;
      end else begin
        m_held++;
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      in_turn = (m_gap == 1);
      m_gap = 0;
      w = pick(req);
      if (w < 0) begin
`ifdef TBUS_PARK_EN
        if (in_turn) begin m_enb = m_owner; m_parked = 1; end
`endif
      end else if (!in_turn && m_parked && w != m_owner) begin
        m_enb = -1; m_parked = 0; m_gap = TA;
      end else begin
        m_gnt = 1; m_enb = w; m_owner = w; m_ptr = (w + 1) % N;
        m_held = 1; m_parked = 0;
      end
    end
  endtask

  task automatic check_cycle();
    logic [N-1:0] eg;
    logic [N-1:0] ee;
    int idx;
    eg = '0; ee = '0;
    if (m_gnt) eg[m_owner] = 1'b1;
    if (m_enb >= 0) ee[m_enb] = 1'b1;
    chk("gnt",    32'(GNT),   32'(eg));
    chk("enb",    32'(ENB),   32'(ee));
    chk("owner",  32'(OWNER), 32'(m_owner));
    chk("busy",   32'(BUSY),  32'(m_gnt || m_gap > 0));
    chk("enb_onehot", 32'($countones(ENB) <= 1), 32'(1));
    if (ENB == '0) begin
      zero_run++;
    end else begin
      idx = 0;
      for (int i = 0; i < N; i++) if (ENB[i]) idx = i;
      if (last_idx >= 0 && idx != last_idx)
        chk("ta_gap", 32'(zero_run >= TA), 32'(1));
      last_idx = idx;
      zero_run = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (GNT[i]) begin
        if (waits[i] > 0) chk("wait_bound", 32'(waits[i] <= BOUND), 32'(1));
        waits[i] = 0;
      end else if (REQ[i]) begin
        waits[i]++;
      end
    end
  endtask

  // One cycle: check this cycle's outputs, then apply this cycle's inputs.
  task automatic tick(input logic [N-1:0] req, input logic [N-1:0] last, input logic rst);
    @(negedge clk);
    check_cycle();
    REQ = req; LAST = last; RST = rst;
    model_step(req, last, rst);
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] l;
    RST = 1'b1; REQ = '0; LAST = '0;
    model_reset();
    tick('0, '0, 1'b1);

    // Single requester, LAST ends the burst, then turnaround to idle.
    tick(4'b0010, '0, 1'b0);                       // c0
    tick(4'b0010, '0, 1'b0);                       // c1
    chk("t1_gnt", 32'(GNT), 32'(4'b0010));
    chk("t1_enb", 32'(ENB), 32'(4'b0010));
    chk("t1_owner", 32'(OWNER), 32'(1));
    chk("t1_busy", 32'(BUSY), 32'(1));
    tick(4'b0010, '0, 1'b0);                       // c2
    tick(4'b0010, '0, 1'b0);                       // c3
    tick(4'b0010, 4'b0010, 1'b0);                  // c4
    chk("t1_enb_last", 32'(ENB), 32'(4'b0010));
    tick('0, '0, 1'b0);                            // c5
    chk("t1_enb_off", 32'(ENB), 32'(0));
    chk("t1_busy_turn", 32'(BUSY), 32'(1));
    tick('0, '0, 1'b0);                            // c6
    tick('0, '0, 1'b0);                            // c7
    chk("t1_idle_busy", 32'(BUSY), 32'(0));
    chk("t1_idle_gnt", 32'(GNT), 32'(0));

    // Two requesters from reset: 0 first, 2 after a TA-cycle gap.
    tick('0, '0, 1'b1);
    tick(4'b0101, '0, 1'b0);                       // c0: reset state visible
    chk("rst_gnt", 32'(GNT), 32'(0));
    chk("rst_enb", 32'(ENB), 32'(0));
    chk("rst_owner", 32'(OWNER), 32'(0));
    chk("rst_busy", 32'(BUSY), 32'(0));
    tick(4'b0101, '0, 1'b0);                       // c1
    chk("t2_enb0", 32'(ENB), 32'(4'b0001));
    tick(4'b0101, '0, 1'b0);                       // c2
    tick(4'b0101, 4'b0001, 1'b0);                  // c3
    tick(4'b0100, '0, 1'b0);                       // c4
    chk("t2_gap_a", 32'(ENB), 32'(0));
    tick(4'b0100, '0, 1'b0);                       // c5
    chk("t2_gap_b", 32'(ENB), 32'(0));
    tick(4'b0100, 4'b0100, 1'b0);                  // c6
    chk("t2_enb2", 32'(ENB), 32'(4'b0100));
    chk("t2_owner", 32'(OWNER), 32'(2));

    // Timeout alternation between requesters 0 and 3.
    tick('0, '0, 1'b1);
    for (int c = 0; c <= 37; c++) begin
      tick(4'b1001, '0, 1'b0);
      if (c == 16) chk("t3_hold_end", 32'(ENB), 32'(4'b0001));
      if (c == 17) chk("t3_gap_a", 32'(ENB), 32'(0));
      if (c == 18) chk("t3_gap_b", 32'(ENB), 32'(0));
      if (c == 19) chk("t3_enb3", 32'(ENB), 32'(4'b1000));
      if (c == 34) chk("t3_enb3_end", 32'(ENB), 32'(4'b1000));
      if (c == 35) chk("t3_gap_c", 32'(ENB), 32'(0));
      if (c == 37) chk("t3_enb0_again", 32'(ENB), 32'(4'b0001));
    end

    // Reset in the third DRIVE cycle, then a fresh grant one cycle later.
    tick('0, '0, 1'b1);
    tick(4'b0010, '0, 1'b0);                       // c0
    tick(4'b0010, '0, 1'b0);                       // c1
    tick(4'b0010, '0, 1'b0);                       // c2
    tick(4'b0010, '0, 1'b1);                       // c3
    tick(4'b0100, '0, 1'b0);                       // c4
    chk("t4_gnt", 32'(GNT), 32'(0));
    chk("t4_enb", 32'(ENB), 32'(0));
    chk("t4_owner", 32'(OWNER), 32'(0));
    chk("t4_busy", 32'(BUSY), 32'(0));
    tick(4'b0100, 4'b0100, 1'b0);                  // c5
    chk("t4_regrant", 32'(GNT), 32'(4'b0100));
    tick('0, '0, 1'b0);

`ifdef TBUS_PARK_EN
    // Parking: owner 1 parks, re-grants without gap; owner 2 needs a TURN.
    tick('0, '0, 1'b1);
    tick(4'b0010, '0, 1'b0);                       // c0
    tick(4'b0010, 4'b0010, 1'b0);                  // c1
    tick('0, '0, 1'b0);                            // c2
    tick('0, '0, 1'b0);                            // c3
    tick(4'b0010, '0, 1'b0);                       // c4
    chk("p_parked_enb", 32'(ENB), 32'(4'b0010));
    chk("p_parked_gnt", 32'(GNT), 32'(0));
    tick(4'b0010, 4'b0010, 1'b0);                  // c5
    chk("p_regrant", 32'(GNT), 32'(4'b0010));
    tick('0, '0, 1'b0);                            // c6
    tick('0, '0, 1'b0);                            // c7
    tick(4'b0100, '0, 1'b0);                       // c8
    tick(4'b0100, '0, 1'b0);                       // c9
    chk("p_switch_off", 32'(ENB), 32'(0));
    tick(4'b0100, '0, 1'b0);                       // c10
    tick(4'b0100, 4'b0100, 1'b0);                  // c11
    chk("p_switch_on", 32'(ENB), 32'(4'b0100));
    tick('0, '0, 1'b0);
`endif

    // Random traffic: requests hold until granted, owners may drop or end.
    tick('0, '0, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!REQ[i])                      r[i] = ($urandom % 4 == 0);
        else if (m_gnt && m_owner == i)   r[i] = ($urandom % 5 != 0);
        else                              r[i] = 1'b1;
        l[i] = ($urandom % 6 == 0);
      end
      tick(r, l, ($urandom % 500 == 0));
    end
    tick('0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
